// File: rtl/inv_sub_bytes_iter_if.sv
// Block-in / block-out handshake bundle for the iterative InvSubBytes engine.
// The slave is the engine and the master is the upstream/downstream pair.
interface inv_sub_bytes_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] text_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] text_out;

  modport master (
    output in_valid, text_in, out_ready,
    input  in_ready, out_valid, text_out
  );

  modport slave (
    input  in_valid, text_in, out_ready,
    output in_ready, out_valid, text_out
  );
endinterface

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes engine: LANES bytes per cycle, result valid 16/LANES cycles after accept.
// Accepts only when idle; the result is held in DONE until out_ready, stalling indefinitely.
module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inv_sub_bytes_iter_if.slave   bus,
  output logic                  busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // FIPS-197 inverse S-box, entry 0x00 in the most-significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [127:0]   w_q;
  logic [127:0]   w_d;
  logic           in_rdy_q;
  logic           out_vld_q;
  logic           busy_q;

  // Substitute only the chunk selected by cnt_q; chunk 0 sits at bits [127:...].
  always_comb begin
    w_d = w_q;
    for (int l = 0; l < LANES; l++) begin
      w_d[127 - 8*(int'(cnt_q)*LANES + l) -: 8] =
        inv_sbox(w_q[127 - 8*(int'(cnt_q)*LANES + l) -: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      w_q       <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            w_q      <= bus.text_in;
            cnt_q    <= '0;
            state_q  <= BUSY;
            in_rdy_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        BUSY: begin
          w_q <= w_d;
          if (cnt_q == CW'(N - 1)) begin
            cnt_q     <= '0;
            state_q   <= DONE;
            out_vld_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q   <= IDLE;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            in_rdy_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_rdy_q  <= 1'b1;
          out_vld_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = out_vld_q;
  assign bus.text_out  = w_q;
  assign busy          = busy_q;

endmodule
